// File: rtl/noc_msg_hdr_encoder.sv
// rtl/noc_msg_hdr_encoder.sv - frames a message request plus a body flit stream into one header flit and body flits
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MSG_DST_CHIPID_WIDTH
`define MSG_DST_CHIPID_WIDTH 14
`endif
`ifndef MSG_DST_X_WIDTH
`define MSG_DST_X_WIDTH 8
`endif
`ifndef MSG_DST_Y_WIDTH
`define MSG_DST_Y_WIDTH 8
`endif
`ifndef MSG_DST_FBITS_WIDTH
`define MSG_DST_FBITS_WIDTH 4
`endif
`ifndef MSG_SRC_FBITS_WIDTH
`define MSG_SRC_FBITS_WIDTH 4
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 22
`endif
`ifndef MSG_TYPE_WIDTH
`define MSG_TYPE_WIDTH 8
`endif
`ifndef MSG_METADATA_FLITS_WIDTH
`define MSG_METADATA_FLITS_WIDTH 8
`endif
`ifndef PKT_IF_FBITS
`define PKT_IF_FBITS 4'd8
`endif

module noc_msg_hdr_encoder #(
   parameter int NOC_DATA_W = `NOC_DATA_WIDTH,
   parameter int SRC_X = 0,
   parameter int SRC_Y = 0,
   parameter logic [`MSG_SRC_FBITS_WIDTH-1:0] SRC_FBITS = `PKT_IF_FBITS,
   parameter int LEN_BYTES_W = 16
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_val,
   input  logic [`MSG_DST_X_WIDTH-1:0]      req_dst_x,
   input  logic [`MSG_DST_Y_WIDTH-1:0]      req_dst_y,
   input  logic [`MSG_DST_FBITS_WIDTH-1:0]  req_dst_fbits,
   input  logic [`MSG_TYPE_WIDTH-1:0]       req_msg_type,
   input  logic [LEN_BYTES_W-1:0]           req_bytes,
   output logic                             req_rdy,
   input  logic                             data_val,
   input  logic [NOC_DATA_W-1:0]            data,
   output logic                             data_rdy,
   output logic                             noc_val,
   output logic [NOC_DATA_W-1:0]            noc_data,
   input  logic                             noc_rdy
);
   localparam int CHIP_W = `MSG_DST_CHIPID_WIDTH;
   localparam int X_W = `MSG_DST_X_WIDTH;
   localparam int Y_W = `MSG_DST_Y_WIDTH;
   localparam int DFB_W = `MSG_DST_FBITS_WIDTH;
   localparam int SFB_W = `MSG_SRC_FBITS_WIDTH;
   localparam int LEN_W = `MSG_LENGTH_WIDTH;
   localparam int TYPE_W = `MSG_TYPE_WIDTH;
   localparam int META_W = `MSG_METADATA_FLITS_WIDTH;
   localparam int BASE_FLIT_W = 2*CHIP_W + 2*X_W + 2*Y_W + DFB_W + SFB_W + LEN_W + TYPE_W + META_W;
   localparam int FLIT_BYTES = NOC_DATA_W / 8;
   localparam int FLIT_SHIFT = $clog2(FLIT_BYTES);
   // One extra bit so a near-maximal byte count rounds up instead of wrapping.
   localparam int CNT_W = LEN_BYTES_W + 1;

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [CNT_W-1:0]       remaining;
   logic [NOC_DATA_W-1:0]  hdr_reg;
   logic [CNT_W-1:0]       byte_sum;
   logic [CNT_W-1:0]       nflits;
   logic [LEN_W-1:0]       msg_len;
   logic [BASE_FLIT_W-1:0] base_flit;

   assign byte_sum = {1'b0, req_bytes} + CNT_W'(FLIT_BYTES - 1);
   assign nflits   = byte_sum >> FLIT_SHIFT;
   assign msg_len  = LEN_W'(nflits);

   assign base_flit = {{CHIP_W{1'b0}}, req_dst_x, req_dst_y, req_dst_fbits, msg_len, req_msg_type,
                       {CHIP_W{1'b0}}, X_W'(SRC_X), Y_W'(SRC_Y), SRC_FBITS, {META_W{1'b0}}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Header is captured only on acceptance so it stays stable through HDR stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         hdr_reg   <= '0;
      end else if (state == IDLE && req_val && req_rdy) begin
         remaining <= nflits;
         hdr_reg   <= {base_flit, {(NOC_DATA_W - BASE_FLIT_W){1'b0}}};
      end else if (state == DATA && data_val && data_rdy) begin
         remaining <= remaining - CNT_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      req_rdy    = 1'b0;
      data_rdy   = 1'b0;
      noc_val    = 1'b0;
      noc_data   = '0;
      case (state)
         IDLE: begin
            req_rdy = ~rst;
            if (req_val && !rst) begin
               state_next = HDR;
            end
         end
         HDR: begin
            noc_val  = 1'b1;
            noc_data = hdr_reg;
            if (noc_rdy) begin
               state_next = (remaining == '0) ? IDLE : DATA;
            end
         end
         DATA: begin
            noc_val  = data_val;
            noc_data = data;
            data_rdy = noc_rdy;
            if (data_val && noc_rdy && remaining == CNT_W'(1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_noc_msg_hdr_encoder.sv
// tb/tb_noc_msg_hdr_encoder.sv - randomized self-checking bench for noc_msg_hdr_encoder
`timescale 1ns/1ps
module tb_noc_msg_hdr_encoder;
   localparam int W = 512;
   localparam int SRC_X_P = 5;
   localparam int SRC_Y_P = 6;
   localparam int SRC_FB_P = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic           req_val;
   logic [7:0]     req_dst_x;
   logic [7:0]     req_dst_y;
   logic [3:0]     req_dst_fbits;
   logic [7:0]     req_msg_type;
   logic [15:0]    req_bytes;
   logic           req_rdy;
   logic           data_val;
   logic [W-1:0]   data;
   logic           data_rdy;
   logic           noc_val;
   logic [W-1:0]   noc_data;
   logic           noc_rdy;

   int checks = 0;
   int errors = 0;

   noc_msg_hdr_encoder #(
      .NOC_DATA_W(W), .SRC_X(SRC_X_P), .SRC_Y(SRC_Y_P), .SRC_FBITS(4'(SRC_FB_P)), .LEN_BYTES_W(16)
   ) dut (
      .clk(clk), .rst(rst),
      .req_val(req_val), .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_dst_fbits(req_dst_fbits),
      .req_msg_type(req_msg_type), .req_bytes(req_bytes), .req_rdy(req_rdy),
      .data_val(data_val), .data(data), .data_rdy(data_rdy),
      .noc_val(noc_val), .noc_data(noc_data), .noc_rdy(noc_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // Header fields are placed from the MSB down by bit position.
   function automatic logic [W-1:0] model_hdr(input int x, input int y, input int f, input int t, input int bytes);
      logic [W-1:0] h;
      int pos;
      int nfl;
      h = '0;
      pos = W;
      nfl = (bytes + 63) / 64;
      pos -= 14;
      pos -= 8;  h |= W'(x) << pos;
      pos -= 8;  h |= W'(y) << pos;
      pos -= 4;  h |= W'(f) << pos;
      pos -= 22; h |= W'(nfl) << pos;
      pos -= 8;  h |= W'(t) << pos;
      pos -= 14;
      pos -= 8;  h |= W'(SRC_X_P) << pos;
      pos -= 8;  h |= W'(SRC_Y_P) << pos;
      pos -= 4;  h |= W'(SRC_FB_P) << pos;
      return h;
   endfunction

   // sched=1: noc_rdy low 5 cycles in HDR and 3 cycles before the second body flit.
   // abort>=0: reset is pulsed after that many body flits.
   task automatic run_msg(input int x, input int y, input int f, input int t, input int bytes,
                          input int stall_pct, input bit sched, input int abort);
      logic [W-1:0] exp_hdr;
      logic [W-1:0] cur_word;
      int nfl, total, sent, cyc, stall_cnt;
      bit hs;
      nfl = (bytes + 63) / 64;
      total = (abort >= 0) ? abort + 1 : nfl + 1;
      exp_hdr = model_hdr(x, y, f, t, bytes);
      cur_word = rand_word();
      @(negedge clk);
      req_val = 1'b1; req_dst_x = 8'(x); req_dst_y = 8'(y); req_dst_fbits = 4'(f);
      req_msg_type = 8'(t); req_bytes = 16'(bytes);
      noc_rdy = 1'b0; data_val = 1'b0;
      #1;
      check("req_rdy_idle", W'(req_rdy), W'(1));
      @(posedge clk);
      #1;
      req_val = 1'b0; req_bytes = 16'($urandom); req_dst_x = 8'($urandom); req_msg_type = 8'($urandom);
      sent = 0; cyc = 0; stall_cnt = 0;
      while (sent < total && cyc < 5000) begin
         @(negedge clk);
         if (sched)
            noc_rdy = !((sent == 0 && stall_cnt < 5) || (sent == 2 && stall_cnt < 3));
         else
            noc_rdy = ($urandom_range(99) >= stall_pct);
         if (sched) data_val = 1'b1;
         else if (sent == 0) data_val = 1'($urandom_range(1));
         else data_val = ($urandom_range(99) >= stall_pct);
         data = cur_word;
         #1;
         check("noc_val", W'(noc_val), (sent == 0) ? W'(1) : W'(data_val));
         if (sent == 0) begin
            check("hdr_flit", noc_data, exp_hdr);
            check("data_rdy_hdr", W'(data_rdy), W'(0));
            check("req_rdy_busy", W'(req_rdy), W'(0));
            hs = noc_rdy;
         end else begin
            if (data_val) check("body_flit", noc_data, cur_word);
            check("data_rdy_body", W'(data_rdy), W'(noc_rdy));
            hs = data_val && noc_rdy;
         end
         @(posedge clk);
         if (hs) begin
            sent++; stall_cnt = 0; cur_word = rand_word();
         end else if (!noc_rdy) begin
            stall_cnt++;
         end
         cyc++;
      end
      check("flit_count", W'(sent), W'(total));
      @(negedge clk);
      data_val = 1'b1; noc_rdy = 1'b1; data = rand_word();
      if (abort >= 0) begin
         rst = 1'b1;
         #1;
         check("rst_noc_val", W'(noc_val), W'(0));
         check("rst_data_rdy", W'(data_rdy), W'(0));
         check("rst_req_rdy", W'(req_rdy), W'(0));
         check("rst_noc_data", noc_data, W'(0));
         @(negedge clk);
         rst = 1'b0; data_val = 1'b0;
         #1;
         check("rst_release_req_rdy", W'(req_rdy), W'(1));
      end else begin
         #1;
         check("bubble_noc_val", W'(noc_val), W'(0));
         check("bubble_data_rdy", W'(data_rdy), W'(0));
         check("bubble_req_rdy", W'(req_rdy), W'(1));
      end
   endtask

   initial begin
      rst = 1'b1; req_val = 1'b0; req_dst_x = '0; req_dst_y = '0; req_dst_fbits = '0;
      req_msg_type = '0; req_bytes = '0; data_val = 1'b0; data = '0; noc_rdy = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_req_rdy", W'(req_rdy), W'(0));
      check("reset_noc_val", W'(noc_val), W'(0));
      check("reset_data_rdy", W'(data_rdy), W'(0));
      check("reset_noc_data", noc_data, W'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_reset_req_rdy", W'(req_rdy), W'(1));

      run_msg(2, 3, 1, 13, 0, 0, 1'b0, -1);
      run_msg(4, 7, 2, 13, 64, 0, 1'b0, -1);
      run_msg(1, 1, 3, 13, 65, 0, 1'b0, -1);
      run_msg(9, 8, 5, 7, 256, 0, 1'b1, -1);
      run_msg(255, 255, 15, 255, 65535, 0, 1'b0, -1);
      run_msg(3, 4, 1, 13, 256, 0, 1'b0, 2);
      run_msg(6, 2, 0, 13, 64, 0, 1'b0, -1);
      for (int i = 0; i < 8; i++)
         run_msg($urandom_range(255), $urandom_range(255), $urandom_range(15), $urandom_range(255),
                 $urandom_range(400), 30, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
